// File: rtl/multicycle_control.sv
// multicycle_control: Moore main FSM plus ALU and immediate decoders driving an RV32I-subset multicycle datapath.
// Revision 1.0 - initial release.
`default_nettype none

module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] immSrc,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  state_t     cur_state, next_state, target;
  logic       pc_update_r, branch_r, adr_src_r, mem_write_r, ir_write_r, reg_write_r;
  logic [1:0] result_src_r, alu_src_a_r, alu_src_b_r, alu_op_r;
  logic [1:0] alu_op;

  always_comb begin
    next_state = FETCH;
    case (cur_state)
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_I:         next_state = EXECUTEI;
          OP_JAL:       next_state = JAL;
          OP_BEQ:       next_state = BEQ;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = FETCH;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      JAL:      next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BEQ:      next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

  assign target = reset ? FETCH : next_state;

  // Moore outputs are registered by decoding the state being entered.
  always_ff @(posedge clk) begin
    cur_state    <= target;
    pc_update_r  <= 1'b0;
    branch_r     <= 1'b0;
    adr_src_r    <= 1'b0;
    mem_write_r  <= 1'b0;
    ir_write_r   <= 1'b0;
    reg_write_r  <= 1'b0;
    result_src_r <= 2'b00;
    alu_src_a_r  <= 2'b00;
    alu_src_b_r  <= 2'b00;
    alu_op_r     <= 2'b00;
    case (target)
      FETCH: begin
        ir_write_r   <= 1'b1;
        alu_src_b_r  <= 2'b10;
        result_src_r <= 2'b10;
        pc_update_r  <= 1'b1;
      end
      DECODE: begin
        alu_src_a_r <= 2'b01;
        alu_src_b_r <= 2'b01;
      end
      MEMADR: begin
        alu_src_a_r <= 2'b10;
        alu_src_b_r <= 2'b01;
      end
      MEMREAD:  adr_src_r <= 1'b1;
      MEMWB: begin
        result_src_r <= 2'b01;
        reg_write_r  <= 1'b1;
      end
      MEMWRITE: begin
        adr_src_r   <= 1'b1;
        mem_write_r <= 1'b1;
      end
      EXECUTER: begin
        alu_src_a_r <= 2'b10;
        alu_op_r    <= 2'b10;
      end
      EXECUTEI: begin
        alu_src_a_r <= 2'b10;
        alu_src_b_r <= 2'b01;
        alu_op_r    <= 2'b10;
      end
      ALUWB:    reg_write_r <= 1'b1;
      JAL: begin
        alu_src_a_r <= 2'b01;
        alu_src_b_r <= 2'b10;
        pc_update_r <= 1'b1;
      end
      BEQ: begin
        alu_src_a_r <= 2'b10;
        alu_op_r    <= 2'b01;
        branch_r    <= 1'b1;
      end
      default: ;
    endcase
  end

  // Reset takes effect on outputs immediately so an aborted instruction writes nothing.
  assign PCWrite   = ~reset & (pc_update_r | (branch_r & zero));
  assign IRWrite   = ~reset & ir_write_r;
  assign RegWrite  = ~reset & reg_write_r;
  assign MemWrite  = ~reset & mem_write_r;
  assign AdrSrc    = reset ? 1'b0  : adr_src_r;
  assign ResultSrc = reset ? 2'b10 : result_src_r;
  assign ALUSrcA   = reset ? 2'b00 : alu_src_a_r;
  assign ALUSrcB   = reset ? 2'b10 : alu_src_b_r;
  assign alu_op    = reset ? 2'b00 : alu_op_r;
  assign state     = cur_state;

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

  always_comb begin
    immSrc = 2'b00;
    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BEQ:  immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed table-driven bench for the multicycle controller.
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, immSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] ILL = 7'b0000000;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .immSrc(immSrc), .state(state)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc}
  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic z, input logic [3:0] st,
                               input logic [4:0] w, input logic [1:0] rs, input logic [1:0] sa,
                               input logic [1:0] sb, input logic [2:0] alu, input logic [1:0] imm);
    vec_t v;
    v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z;
    v.exp = {st, w, rs, sa, sb, alu, imm};
    return v;
  endfunction

  function automatic logic [19:0] actual();
    return {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc};
  endfunction

  task automatic check(input string name, input logic [19:0] exp);
    logic [19:0] act;
    act = actual();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got state=%0d w=%b rs=%b sa=%b sb=%b alu=%b imm=%b, expected state=%0d w=%b rs=%b sa=%b sb=%b alu=%b imm=%b",
               name, act[19:16], act[15:11], act[10:9], act[8:7], act[6:5], act[4:2], act[1:0],
               exp[19:16], exp[15:11], exp[10:9], exp[8:7], exp[6:5], exp[4:2], exp[1:0]);
    end
  endtask

  task automatic drive(input logic rst, input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    reset = rst; op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  initial begin
    bit found;
    // lw: 0,1,2,3,4
    vecs.push_back(row(0, LW, 3'b000, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    vecs.push_back(row(0, LW, 3'b000, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00));
    vecs.push_back(row(0, LW, 3'b000, 0, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00));
    vecs.push_back(row(0, LW, 3'b000, 0, 0, 4'd3, 5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    vecs.push_back(row(0, LW, 3'b000, 0, 0, 4'd4, 5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00));
    // sw: 0,1,2,5
    vecs.push_back(row(0, SW, 3'b010, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01));
    vecs.push_back(row(0, SW, 3'b010, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01));
    vecs.push_back(row(0, SW, 3'b010, 0, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01));
    vecs.push_back(row(0, SW, 3'b010, 0, 0, 4'd5, 5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01));
    // sub
    vecs.push_back(row(0, RT, 3'b000, 1, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    vecs.push_back(row(0, RT, 3'b000, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00));
    vecs.push_back(row(0, RT, 3'b000, 1, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00));
    vecs.push_back(row(0, RT, 3'b000, 1, 0, 4'd7, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    // slt
    vecs.push_back(row(0, RT, 3'b010, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    vecs.push_back(row(0, RT, 3'b010, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00));
    vecs.push_back(row(0, RT, 3'b010, 0, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b101, 2'b00));
    vecs.push_back(row(0, RT, 3'b010, 0, 0, 4'd7, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    // and, then or (funct3 changed while in EXECUTER is not possible; use separate instructions)
    vecs.push_back(row(0, RT, 3'b111, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    vecs.push_back(row(0, RT, 3'b111, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00));
    vecs.push_back(row(0, RT, 3'b111, 0, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b010, 2'b00));
    vecs.push_back(row(0, RT, 3'b111, 0, 0, 4'd7, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    vecs.push_back(row(0, RT, 3'b110, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    vecs.push_back(row(0, RT, 3'b110, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00));
    vecs.push_back(row(0, RT, 3'b110, 0, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b011, 2'b00));
    vecs.push_back(row(0, RT, 3'b110, 0, 0, 4'd7, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    // addi with funct7b5=1 stays an add
    vecs.push_back(row(0, IT, 3'b000, 1, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    vecs.push_back(row(0, IT, 3'b000, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00));
    vecs.push_back(row(0, IT, 3'b000, 1, 0, 4'd8, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00));
    vecs.push_back(row(0, IT, 3'b000, 1, 0, 4'd7, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    // beq taken: zero high throughout must only matter in BEQ
    vecs.push_back(row(0, BQ, 3'b000, 0, 1, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10));
    vecs.push_back(row(0, BQ, 3'b000, 0, 1, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10));
    vecs.push_back(row(0, BQ, 3'b000, 0, 1, 4'd10, 5'b10000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10));
    // beq not taken
    vecs.push_back(row(0, BQ, 3'b000, 0, 0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10));
    vecs.push_back(row(0, BQ, 3'b000, 0, 0, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10));
    vecs.push_back(row(0, BQ, 3'b000, 0, 0, 4'd10, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10));
    // jal: 0,1,9,7
    vecs.push_back(row(0, JL, 3'b000, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b11));
    vecs.push_back(row(0, JL, 3'b000, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b11));
    vecs.push_back(row(0, JL, 3'b000, 0, 0, 4'd9, 5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11));
    vecs.push_back(row(0, JL, 3'b000, 0, 0, 4'd7, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11));
    // illegal: 0,1,0
    vecs.push_back(row(0, ILL, 3'b000, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    vecs.push_back(row(0, ILL, 3'b000, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00));
    vecs.push_back(row(0, ILL, 3'b000, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));

    drive(1, LW, 3'b000, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check("reset_hold", {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
      #1 check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset asserted mid-instruction in MEMWRITE must abort the store.
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      drive(0, SW, 3'b010, 0, 0);
      #1 if (state == 4'd5) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reach_memwrite: state=%0d, expected 5 within 10 cycles", state);
    end
    check("memwrite_before_reset", {4'd5, 5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01});
    reset = 1'b1;
    #1 check("reset_in_memwrite", {4'd5, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01});
    @(negedge clk);
    #1 check("reset_second_cycle", {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01});

    // Reset during a taken BEQ must suppress PCWrite.
    @(negedge clk);
    drive(0, BQ, 3'b000, 0, 1);
    #1 check("release_fetch", {4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10});
    @(negedge clk);
    #1 check("beq_decode", {4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10});
    @(negedge clk);
    reset = 1'b1;
    #1 check("reset_in_beq", {4'd10, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10});
    @(negedge clk);
    reset = 1'b0;
    #1 check("after_beq_reset", {4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle controller FSM that sits directly upstream of the datapath and drives every datapath control input from the fetched instruction word and the ALU `zero` flag.
- Supports this RV32I subset: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.
- Contains a Moore main FSM, a combinational ALU decoder and a combinational immediate-source decoder.

Parameters:
- None. Opcode and state encodings are fixed as listed under Behaviour.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  7  instruccion[6:0].
- funct3  input  3  instruccion[14:12].
- funct7b5  input  1  instruccion[30].
- zero  input  1  ALU zero flag from the datapath.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address mux select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  data memory write enable.
- IRWrite  output  1  instruction/oldPC register enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  ALU A mux select: 00 = PC, 01 = oldPC, 10 = rs1.
- ALUSrcB  output  2  ALU B mux select: 00 = rs2, 01 = imm, 10 = const 4.
- ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- immSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- state  output  4  current FSM state, for debug.

Behaviour:
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10.
- Reset: on a clk edge with reset=1, state <= FETCH.
- While reset=1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. All other outputs take their FETCH values.
- A reset asserted in any state aborts the instruction; no write enable is asserted during or after that edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR for lw/sw; EXECUTER for R; EXECUTEI for I-ALU; JAL for jal; BEQ for beq.
  - DECODE -> FETCH for any other opcode; no write enable is asserted.
  - MEMADR -> MEMREAD for op=lw, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER -> ALUWB; EXECUTEI -> ALUWB; JAL -> ALUWB; ALUWB -> FETCH.
  - BEQ -> FETCH.
  - Any unused encoding (11-15) -> FETCH.
- Moore outputs per state (unlisted signals = 0; ALUOp is internal):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1, ResultSrc=00.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- PCWrite = PCUpdate | (Branch & zero). This is the only combinational path from zero to an output.
- ALU decoder:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10 with funct3 000: 001 if op[5]&funct7b5, else 000.
  - ALUOp 10 with funct3 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
  - addi with funct7b5=1 -> 000, because op[5]=0.
- immSrc is decoded from op only, independent of state: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- Cycles per instruction: lw 5, sw 4, R 4, I-ALU 4, jal 4, beq 3, illegal 2.

Test Plan:
- Reset: reset=1 for 2 cycles in arbitrary state -> state=0, PCWrite=IRWrite=RegWrite=MemWrite=0. Release reset -> next cycle IRWrite=1, PCWrite=1.
- lw (op=0000011): state sequence 0,1,2,3,4,0. MemWrite never 1. RegWrite=1 only in state 4 with ResultSrc=01. immSrc=00.
- sw (op=0100011): sequence 0,1,2,5,0. MemWrite=1 and AdrSrc=1 only in state 5. RegWrite never 1. immSrc=01.
- R-type sub (funct3=000, funct7b5=1): ALUControl=001 in state 6. Same with funct3=010 -> 101, funct3=111 -> 010. addi with funct7b5=1 -> ALUControl=000 in state 8.
- beq: with zero=1 in state 10 -> PCWrite=1, ALUControl=001. With zero=0 -> PCWrite=0. Next state is 0 in both cases.
- jal (op=1101111): sequence 0,1,9,7,0. PCWrite=1 in state 9. RegWrite=1 in state 7. immSrc=11. An illegal op such as 0000000 -> sequence 0,1,0 with no writes.
